// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and control-bundle constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  localparam logic [15:0] NOP_INSTR = 16'h1000;
  localparam logic [3:0]  REG_ZERO  = 4'd0;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_flush;
    logic ex_mem_write;
    logic mem_wb_write;
  } ctrl_t;

  localparam ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  // Hold PC and IF/ID, inject a bubble into EX, let older instructions advance.
  localparam ctrl_t CTRL_BUBBLE = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  // Hold PC, replace IF/ID contents with a NOP, everything else advances.
  localparam ctrl_t CTRL_SQUASH = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  localparam ctrl_t CTRL_RUN    = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use compare: EX holds a load whose non-zero destination is read by the ID instruction.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [3:0] i_id_rs,
  input  logic [3:0] i_id_rt,
  input  logic       i_id_uses_rs,
  input  logic       i_id_uses_rt,
  input  logic       i_ex_mem_read,
  input  logic [3:0] i_ex_rd,
  output logic       o_lu_stall
);

  logic w_rs_hit, w_rt_hit;

  assign w_rs_hit   = i_id_uses_rs && (i_id_rs == i_ex_rd);
  assign w_rt_hit   = i_id_uses_rt && (i_id_rt == i_ex_rd);
  assign o_lu_stall = i_ex_mem_read && (i_ex_rd != REG_ZERO) && (w_rs_hit || w_rt_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer owning every pipeline-register enable of the 5-stage core.
// Optional perf counters enabled with `define PIPE_PERF_CNT_EN.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [3:0]       i_id_rs,
  input  logic [3:0]       i_id_rt,
  input  logic             i_id_uses_rs,
  input  logic             i_id_uses_rt,
  input  logic             i_ex_mem_read,
  input  logic [3:0]       i_ex_rd,
  input  logic             i_branch_taken,
  input  logic             i_id_halt,
  input  logic             i_i_busy,
  input  logic             i_d_busy,
  output logic             o_pc_write,
  output logic             o_if_id_write,
  output logic             o_if_id_flush,
  output logic             o_id_ex_write,
  output logic             o_id_ex_flush,
  output logic             o_ex_mem_write,
  output logic             o_mem_wb_write,
  output logic             o_halted,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  state_e        r_state;
  logic [DW-1:0] r_drain_cnt;
  logic          r_sq_pend;
  ctrl_t         w_ctrl, w_out;
  logic          w_lu, w_go_drain, w_set_sq, w_clr_sq;

  hazard_detect u_hazard_detect (
    .i_id_rs       (i_id_rs),
    .i_id_rt       (i_id_rt),
    .i_id_uses_rs  (i_id_uses_rs),
    .i_id_uses_rt  (i_id_uses_rt),
    .i_ex_mem_read (i_ex_mem_read),
    .i_ex_rd       (i_ex_rd),
    .o_lu_stall    (w_lu)
  );

  always_comb begin
    w_ctrl     = CTRL_FREEZE;
    w_go_drain = 1'b0;
    w_set_sq   = 1'b0;
    w_clr_sq   = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (i_d_busy) begin
          w_ctrl = CTRL_FREEZE;
        end else if (w_lu) begin
          w_ctrl = CTRL_BUBBLE;
        end else if (i_id_halt) begin
          w_ctrl     = CTRL_SQUASH;
          w_go_drain = 1'b1;
        end else if (r_sq_pend && !i_i_busy) begin
          // Late-arriving wrong-path fetch from an earlier taken branch.
          w_ctrl   = CTRL_SQUASH;
          w_clr_sq = 1'b1;
        end else if (i_branch_taken) begin
          w_ctrl             = CTRL_RUN;
          w_ctrl.if_id_flush = 1'b1;
          w_ctrl.if_id_write = !i_i_busy;
          w_set_sq           = i_i_busy;
        end else if (i_i_busy) begin
          w_ctrl = CTRL_BUBBLE;
        end else begin
          w_ctrl = CTRL_RUN;
        end
      end
      ST_DRAIN: w_ctrl = i_d_busy ? CTRL_FREEZE : CTRL_BUBBLE;
      default:  w_ctrl = CTRL_FREEZE;
    endcase
  end

  assign w_out          = i_rst_n ? w_ctrl : CTRL_FREEZE;
  assign o_pc_write     = w_out.pc_write;
  assign o_if_id_write  = w_out.if_id_write;
  assign o_if_id_flush  = w_out.if_id_flush;
  assign o_id_ex_write  = w_out.id_ex_write;
  assign o_id_ex_flush  = w_out.id_ex_flush;
  assign o_ex_mem_write = w_out.ex_mem_write;
  assign o_mem_wb_write = w_out.mem_wb_write;
  assign o_halted       = i_rst_n && (r_state == ST_HALTED);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_RUN;
      r_drain_cnt <= '0;
      r_sq_pend   <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_go_drain) begin
            r_state     <= ST_DRAIN;
            r_drain_cnt <= DW'(DRAIN_CYCLES);
          end
          if (w_set_sq)      r_sq_pend <= 1'b1;
          else if (w_clr_sq) r_sq_pend <= 1'b0;
        end
        ST_DRAIN: begin
          if (!i_d_busy) begin
            if (r_drain_cnt == DW'(1)) r_state <= ST_HALTED;
            r_drain_cnt <= r_drain_cnt - DW'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (r_state != ST_HALTED) begin
      if (!w_ctrl.pc_write && !(&r_stall_cnt))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if ((w_ctrl.if_id_flush || w_ctrl.id_ex_flush) && !(&r_flush_cnt))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;
`else
  assign o_stall_cnt = '0;
  assign o_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: driver pushes reference-model expectations, monitor pops and compares.
module tb_pipeline_hazard_ctrl;

`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct {
    bit       rst_n;
    bit [3:0] rs, rt, rd;
    bit       urs, urt, mr, bt, hlt, ib, db;
  } in_t;

  typedef struct {
    bit [6:0]  ctl;   // {pc, ifw, iff, idw, idf, exw, mww}
    bit        halted;
    bit [15:0] st, fl;
    int        cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  id_rs = '0, id_rt = '0, ex_rd = '0;
  logic        uses_rs = 1'b0, uses_rt = 1'b0, mem_read = 1'b0;
  logic        br = 1'b0, hlt = 1'b0, ibusy = 1'b0, dbusy = 1'b0;
  logic        pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, memwb_w, halted;
  logic [15:0] stall_cnt, flush_cnt;

  pipeline_hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_uses_rs(uses_rs), .i_id_uses_rt(uses_rt),
    .i_ex_mem_read(mem_read), .i_ex_rd(ex_rd), .i_branch_taken(br), .i_id_halt(hlt),
    .i_i_busy(ibusy), .i_d_busy(dbusy),
    .o_pc_write(pc_w), .o_if_id_write(ifid_w), .o_if_id_flush(ifid_f),
    .o_id_ex_write(idex_w), .o_id_ex_flush(idex_f), .o_ex_mem_write(exmem_w),
    .o_mem_wb_write(memwb_w), .o_halted(halted),
    .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   n_checks = 0, n_pass = 0, cyc = 0;
  bit   done = 1'b0;

  // Reference model: 0 = running, 1 = draining, 2 = halted.
  int   m_mode = 0, m_left = 0;
  bit   m_squash_owed = 0;
  int   m_stalls = 0, m_flushes = 0;

  function automatic in_t idle();
    in_t x;
    x = '{rst_n: 1'b1, rs: 4'd0, rt: 4'd0, rd: 4'd0, urs: 1'b0, urt: 1'b0,
          mr: 1'b0, bt: 1'b0, hlt: 1'b0, ib: 1'b0, db: 1'b0};
    return x;
  endfunction

  task automatic predict(input in_t x, output exp_t e);
    bit reads_load;
    e.cyc = cyc;
    e.halted = 1'b0;
    if (!x.rst_n) begin
      m_mode = 0; m_left = 0; m_squash_owed = 0; m_stalls = 0; m_flushes = 0;
      e.ctl = 7'b0; e.st = 16'd0; e.fl = 16'd0;
      return;
    end
    reads_load = x.mr && x.rd != 0 && ((x.urs && x.rs == x.rd) || (x.urt && x.rt == x.rd));
    e.st = PERF ? 16'(m_stalls) : 16'd0;
    e.fl = PERF ? 16'(m_flushes) : 16'd0;
    if (m_mode == 2) begin
      e.ctl = 7'b0; e.halted = 1'b1;
      return;
    end
    if (x.db)                          e.ctl = 7'b0000000;
    else if (m_mode == 1) begin
      e.ctl = 7'b0001111;
      m_left--;
      if (m_left == 0) m_mode = 2;
    end
    else if (reads_load)               e.ctl = 7'b0001111;
    else if (x.hlt) begin e.ctl = 7'b0111011; m_mode = 1; m_left = 3; end
    else if (m_squash_owed && !x.ib) begin e.ctl = 7'b0111011; m_squash_owed = 0; end
    else if (x.bt) begin
      e.ctl = {1'b1, !x.ib, 5'b11011};
      if (x.ib) m_squash_owed = 1;
    end
    else if (x.ib)                     e.ctl = 7'b0001111;
    else                               e.ctl = 7'b1101011;
    if (!e.ctl[6] && m_stalls < 65535) m_stalls++;
    if ((e.ctl[4] || e.ctl[2]) && m_flushes < 65535) m_flushes++;
  endtask

  task automatic step(input in_t x);
    exp_t e;
    @(posedge clk); #1;
    cyc++;
    rst_n = x.rst_n; id_rs = x.rs; id_rt = x.rt; ex_rd = x.rd;
    uses_rs = x.urs; uses_rt = x.urt; mem_read = x.mr;
    br = x.bt; hlt = x.hlt; ibusy = x.ib; dbusy = x.db;
    predict(x, e);
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input int c, input bit [15:0] got, input bit [15:0] exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s cyc %0d got %0h expected %0h", nm, c, got, exp);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("ctl", e.cyc, 16'({pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, memwb_w}), 16'(e.ctl));
        chk("halted", e.cyc, 16'(halted), 16'(e.halted));
        chk("stall_cnt", e.cyc, stall_cnt, e.st);
        chk("flush_cnt", e.cyc, flush_cnt, e.fl);
      end
    end
  end

  initial begin : driver
    in_t x;
    x = idle(); x.rst_n = 1'b0;
    step(x); step(x);
    // Load-use on rs, then release
    x = idle(); x.mr = 1; x.rd = 4'd3; x.rs = 4'd3; x.rt = 4'd5; x.urs = 1; x.urt = 1;
    step(x);
    x = idle(); x.rs = 4'd3; x.urs = 1; step(x);
    // Load to $0 never stalls
    x = idle(); x.mr = 1; x.rd = 4'd0; x.rs = 4'd0; x.rt = 4'd0; x.urs = 1; x.urt = 1;
    step(x);
    // Taken branch, fetch ready
    x = idle(); x.bt = 1; step(x);
    step(idle());
    // Taken branch during a slow fetch
    x = idle(); x.bt = 1; x.ib = 1; step(x);
    x = idle(); x.ib = 1; step(x); step(x); step(x);
    step(idle()); step(idle());
    // HLT with d_busy mid-drain
    x = idle(); x.hlt = 1; step(x);
    x = idle(); step(x);
    x.db = 1; step(x); step(x);
    x.db = 0; step(x); step(x);
    step(idle()); step(idle());
    x = idle(); x.rst_n = 0; step(x);
    // Reset in the middle of a drain
    x = idle(); x.ib = 1; step(x);
    x = idle(); x.hlt = 1; step(x);
    step(idle());
    x = idle(); x.rst_n = 0; step(x);
    step(idle()); step(idle());
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      x.rst_n = ($urandom_range(99) >= 2);
      x.rs  = 4'($urandom_range(7)); x.rt = 4'($urandom_range(7)); x.rd = 4'($urandom_range(7));
      x.urs = 1'($urandom); x.urt = 1'($urandom); x.mr = ($urandom_range(99) < 40);
      x.bt  = ($urandom_range(99) < 20); x.hlt = ($urandom_range(99) < 3);
      x.ib  = ($urandom_range(99) < 30); x.db = ($urandom_range(99) < 15);
      step(x);
    end
    @(posedge clk); @(posedge clk);
    n_checks++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain_queue left %0d expected 0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
